// File: rtl/act_pkg.sv
// act_pkg: shared types and defaults for the activation sequencer.
// Holds the sequencer state encoding, default widths and an index-width helper.
package act_pkg;

   localparam int ACC_WIDTH_DEF = 32;
   localparam int OUT_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_STORE  = 3'd3,
      ST_FINISH = 3'd4
   } act_seq_state_t;

   // Lane index width: ceil(log2(n)), never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/act_sequencer_if.sv
// act_sequencer_if: request/response link between the sequencer and the
// activation unit.
//
// Handshake: the master raises act_start for exactly one cycle and holds
// act_data stable from that cycle until act_done is seen. The slave answers
// with a one-cycle act_done pulse; act_result is valid only in that cycle.
// An act_done in the same cycle as act_start is not a valid response.
interface act_sequencer_if
   import act_pkg::*;
#(
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int OUT_WIDTH = OUT_WIDTH_DEF
) ();

   logic                 act_start;
   logic [ACC_WIDTH-1:0] act_data;
   logic                 act_done;
   logic [OUT_WIDTH-1:0] act_result;

   modport master (
      output act_start,
      output act_data,
      input  act_done,
      input  act_result
   );

   modport slave (
      input  act_start,
      input  act_data,
      output act_done,
      output act_result
   );

endinterface

// File: rtl/act_watchdog.sv
// act_watchdog: cycle counter for the WAIT state, built only when
// ACT_TIMEOUT_EN is defined. Held at zero while clear is high, counts up
// otherwise and flags expiry in the TIMEOUT_CYCLES-th counted cycle.
`ifdef ACT_TIMEOUT_EN
module act_watchdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = !clear && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Next count: clear, advance, or hold once expired.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (!expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/act_sequencer.sv
// act_sequencer: walks the accumulator lanes of one layer through a shared
// activation unit, one request at a time, and collects the results.
// Optional feature: ACT_TIMEOUT_EN adds a WAIT watchdog that writes 0 to the
// stuck lane and raises a sticky timeout_err.
module act_sequencer
   import act_pkg::*;
#(
   parameter int NUM_NEURONS    = 10,
   parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
   parameter int OUT_WIDTH      = OUT_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  layer_start,
   input  logic [NUM_NEURONS*ACC_WIDTH-1:0]      acc_vec,
   act_sequencer_if.master                       act_if,
   output logic [NUM_NEURONS*OUT_WIDTH-1:0]      layer_out,
   output logic                                  layer_done,
   output logic                                  busy,
   output logic                                  timeout_err,
   output act_seq_state_t                        dbg_state,
   output logic [idx_width(NUM_NEURONS)-1:0]     dbg_index
);

   localparam int IDX_W = idx_width(NUM_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_ISSUE  = ST_ISSUE;
   localparam logic [2:0] S_WAIT   = ST_WAIT;
   localparam logic [2:0] S_STORE  = ST_STORE;
   localparam logic [2:0] S_FINISH = ST_FINISH;

   logic [2:0]                       state_q, state_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic [NUM_NEURONS*ACC_WIDTH-1:0] acc_buf_q, acc_buf_d;
   logic [NUM_NEURONS*OUT_WIDTH-1:0] layer_out_q, layer_out_d;
   logic                             act_start_q, act_start_d;
   logic                             layer_done_q, layer_done_d;
   logic                             busy_q, busy_d;

`ifdef ACT_TIMEOUT_EN
   logic wd_expired;
   logic timeout_err_q, timeout_err_d;

   act_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_q != S_WAIT),
      .expired (wd_expired)
   );

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   // Operand comes straight from the captured buffer, so it cannot move
   // while a request is outstanding.
   assign act_if.act_data  = acc_buf_q[idx_q*ACC_WIDTH +: ACC_WIDTH];
   assign act_if.act_start = act_start_q;
   assign layer_out        = layer_out_q;
   assign layer_done       = layer_done_q;
   assign busy             = busy_q;
   assign dbg_state        = act_seq_state_t'(state_q);
   assign dbg_index        = idx_q;

   // Sequencer next-state, lane write and registered pulse outputs.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_buf_d   = acc_buf_q;
      layer_out_d = layer_out_q;
`ifdef ACT_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (layer_start) begin
               acc_buf_d = acc_vec;
               idx_d     = '0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (act_if.act_done) begin
               layer_out_d[idx_q*OUT_WIDTH +: OUT_WIDTH] = act_if.act_result;
               state_d = S_STORE;
`ifdef ACT_TIMEOUT_EN
            end else if (wd_expired) begin
               layer_out_d[idx_q*OUT_WIDTH +: OUT_WIDTH] = '0;
               timeout_err_d = 1'b1;
               state_d = S_STORE;
`endif
            end
         end
         S_STORE: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Outputs are registered from the next state so they line up with it.
      act_start_d  = (state_d == S_ISSUE);
      layer_done_d = (state_d == S_FINISH);
      busy_d       = (state_d != S_IDLE);
   end

   // Sequencer registers; reset abandons any layer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         acc_buf_q    <= '0;
         layer_out_q  <= '0;
         act_start_q  <= 1'b0;
         layer_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_buf_q    <= acc_buf_d;
         layer_out_q  <= layer_out_d;
         act_start_q  <= act_start_d;
         layer_done_q <= layer_done_d;
         busy_q       <= busy_d;
      end
   end

`ifdef ACT_TIMEOUT_EN
   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err_q <= 1'b0;
      end else begin
         timeout_err_q <= timeout_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_act_sequencer.sv
// tb_act_sequencer: directed bench for act_sequencer with a 4-lane and a
// 1-lane instance, each served by a behavioural activation unit that returns
// operand/2 (truncated toward zero, low OUT_WIDTH bits). The unit captures a
// request on the edge ending the act_start cycle and answers with act_done
// high LAT+1 cycles after the act_start cycle.
module tb_act_sequencer;
   import act_pkg::*;

   localparam int LAT = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- 4-lane instance ----------------
   logic           ls4;
   logic [127:0]   acc4;
   logic [31:0]    out4;
   logic           done4, busy4, terr4;
   act_seq_state_t st4;
   logic [1:0]     idx4;

   act_sequencer_if #(.ACC_WIDTH(32), .OUT_WIDTH(8)) if4 ();

   act_sequencer #(
      .NUM_NEURONS(4), .ACC_WIDTH(32), .OUT_WIDTH(8), .TIMEOUT_CYCLES(16)
   ) dut4 (
      .clk(clk), .rst_n(rst_n), .layer_start(ls4), .acc_vec(acc4),
      .act_if(if4.master), .layer_out(out4), .layer_done(done4),
      .busy(busy4), .timeout_err(terr4), .dbg_state(st4), .dbg_index(idx4)
   );

   // ---------------- 1-lane instance ----------------
   logic           ls1;
   logic [31:0]    acc1;
   logic [7:0]     out1;
   logic           done1, busy1, terr1;
   act_seq_state_t st1;
   logic [0:0]     idx1;

   act_sequencer_if #(.ACC_WIDTH(32), .OUT_WIDTH(8)) if1 ();

   act_sequencer #(
      .NUM_NEURONS(1), .ACC_WIDTH(32), .OUT_WIDTH(8), .TIMEOUT_CYCLES(16)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .layer_start(ls1), .acc_vec(acc1),
      .act_if(if1.master), .layer_out(out1), .layer_done(done1),
      .busy(busy1), .timeout_err(terr1), .dbg_state(st1), .dbg_index(idx1)
   );

   // ---------------- scoreboard counters ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- activation unit models ----------------
   int n_starts4 = 0;
   int mute_at   = -1;   // absolute start number the model never answers
   bit echo      = 1'b0; // answer garbage in the act_start cycle itself
   bit inj       = 1'b0; // one spurious act_done while inj is seen high

   initial begin : model4
      int cnt;
      logic [7:0] pend;
      logic signed [31:0] d;
      cnt = 0;
      pend = '0;
      if4.act_done = 1'b0;
      if4.act_result = '0;
      forever begin
         @(negedge clk);
         if4.act_done = 1'b0;
         if (!rst_n) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  if4.act_done = 1'b1;
                  if4.act_result = pend;
               end
            end
            if (inj) begin
               if4.act_done = 1'b1;
               if4.act_result = 8'hAA;
            end
            if (if4.act_start) begin
               n_starts4++;
               if (echo) begin
                  if4.act_done = 1'b1;
                  if4.act_result = 8'h55;
               end
               if (n_starts4 != mute_at) begin
                  d = $signed(if4.act_data);
                  d = d / 2;
                  pend = d[7:0];
                  cnt = LAT + 1;
               end
            end
         end
      end
   end

   int n_starts1 = 0;

   initial begin : model1
      int cnt;
      logic [7:0] pend;
      logic signed [31:0] d;
      cnt = 0;
      pend = '0;
      if1.act_done = 1'b0;
      if1.act_result = '0;
      forever begin
         @(negedge clk);
         if1.act_done = 1'b0;
         if (!rst_n) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  if1.act_done = 1'b1;
                  if1.act_result = pend;
               end
            end
            if (if1.act_start) begin
               n_starts1++;
               d = $signed(if1.act_data);
               d = d / 2;
               pend = d[7:0];
               cnt = LAT + 1;
            end
         end
      end
   end

   // ---------------- driver: one full 4-lane layer ----------------
   task automatic run_layer(input string tag, input logic [127:0] acc, input logic [31:0] exp,
                            input int exp_lat, input bit reissue, input logic [127:0] acc2);
      logic [31:0] prev;
      int cyc;
      int s0;
      bit busy_bad;
      @(negedge clk);
      chk({tag, " idle_before"}, busy4, 1'b0);
      prev = out4;
      s0 = n_starts4;
      ls4 = 1'b1;
      acc4 = acc;
      @(negedge clk);
      ls4 = 1'b0;
      acc4 = ~acc;  // capture must already have happened
      cyc = 1;
      busy_bad = 1'b0;
      while (!done4 && cyc < 200) begin
         if (!busy4) busy_bad = 1'b1;
         if (cyc == 4) begin
            chk({tag, " untouched_lanes"}, out4, prev);
            if (reissue) begin
               ls4 = 1'b1;
               acc4 = acc2;
            end
         end
         if (cyc == 5) ls4 = 1'b0;
         if (cyc == 12) chk({tag, " lane0_only"}, out4, {prev[31:8], exp[7:0]});
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, cyc, exp_lat);
      chk({tag, " busy_at_done"}, busy4, 1'b1);
      chk({tag, " busy_gap"}, busy_bad, 1'b0);
      chk({tag, " act_starts"}, n_starts4 - s0, 4);
      chk({tag, " layer_out"}, out4, exp);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, done4, 1'b0);
      chk({tag, " busy_after"}, busy4, 1'b0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [127:0] acc;
      logic [31:0]  exp;
   } vec_t;

   vec_t vecs[4];

   // ---------------- main test ----------------
   initial begin : main
      int cyc;
      int s0;
      bit bad;
      bit seen_done;

      vecs[0].acc = {32'sd40, -32'sd3, 32'sd0, 32'sd127};
      vecs[0].exp = {8'sd20, -8'sd1, 8'sd0, 8'sd63};
      vecs[1].acc = {-32'sd255, 32'sd254, 32'sd1, -32'sd1};
      vecs[1].exp = {-8'sd127, 8'sd127, 8'sd0, 8'sd0};
      vecs[2].acc = {32'sd100, -32'sd100, 32'sd7, -32'sd7};
      vecs[2].exp = {8'sd50, -8'sd50, 8'sd3, -8'sd3};
      vecs[3].acc = {32'sd1000, 32'h8000_0000, 32'h7FFF_FFFF, 32'sd2};
      vecs[3].exp = {8'hF4, 8'h00, 8'hFF, 8'h01};

      ls4 = 1'b0;
      acc4 = '0;
      ls1 = 1'b0;
      acc1 = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_state", st4, ST_IDLE);
      chk("rst_act_start", if4.act_start, 1'b0);
      chk("rst_act_data", if4.act_data, 32'h0);
      chk("rst_layer_out", out4, 32'h0);
      chk("rst_layer_done", done4, 1'b0);
      chk("rst_busy", busy4, 1'b0);
      chk("rst_timeout_err", terr4, 1'b0);
      chk("rst_index", idx4, 2'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven layers
      for (int i = 0; i < 4; i++) begin
         run_layer($sformatf("vec%0d", i), vecs[i].acc, vecs[i].exp, 4 * (LAT + 3) + 1, 1'b0, '0);
      end

      // Spurious act_done in IDLE: no write, index unchanged
      @(negedge clk);
      #1 inj = 1'b1;
      @(negedge clk);
      #1 inj = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_done_out", out4, vecs[3].exp);
      chk("idle_done_index", idx4, 2'd3);
      chk("idle_done_state", st4, ST_IDLE);

      // act_done coincident with every act_start must be ignored
      echo = 1'b1;
      run_layer("echo", vecs[0].acc, vecs[0].exp, 4 * (LAT + 3) + 1, 1'b0, '0);
      echo = 1'b0;

      // layer_start reissued during WAIT with another vector
      run_layer("reissue", vecs[1].acc, vecs[1].exp, 4 * (LAT + 3) + 1, 1'b1, vecs[2].acc);

`ifdef ACT_TIMEOUT_EN
      // Lane 1 never answered: written 0 after 16 WAIT cycles
      mute_at = n_starts4 + 2;
      run_layer("timeout", vecs[2].acc, {8'sd50, -8'sd50, 8'sd0, -8'sd3},
                4 * (LAT + 3) + 1 + (16 - (LAT + 1)), 1'b0, '0);
      mute_at = -1;
      chk("timeout_err_set", terr4, 1'b1);
      run_layer("after_timeout", vecs[0].acc, vecs[0].exp, 4 * (LAT + 3) + 1, 1'b0, '0);
      chk("timeout_err_sticky", terr4, 1'b1);
`else
      chk("timeout_err_tied", terr4, 1'b0);
`endif

      // Reset during WAIT of lane 2, late act_done after release
      mute_at = n_starts4 + 3;
      @(negedge clk);
      ls4 = 1'b1;
      acc4 = vecs[2].acc;
      @(negedge clk);
      ls4 = 1'b0;
      cyc = 0;
      while (!(st4 == ST_WAIT && idx4 == 2'd2) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_wait_lane2", cyc < 100, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_state", st4, ST_IDLE);
      chk("midrst_index", idx4, 2'd0);
      chk("midrst_layer_out", out4, 32'h0);
      chk("midrst_busy", busy4, 1'b0);
      chk("midrst_act_start", if4.act_start, 1'b0);
      chk("midrst_act_data", if4.act_data, 32'h0);
      chk("midrst_timeout_err", terr4, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      mute_at = -1;
      #1 inj = 1'b1;
      @(negedge clk);
      #1 inj = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done4) seen_done = 1'b1;
      end
      chk("midrst_no_layer_done", seen_done, 1'b0);
      chk("midrst_out_after", out4, 32'h0);
      chk("midrst_state_after", st4, ST_IDLE);

      // Single-lane instance
      @(negedge clk);
      s0 = n_starts1;
      ls1 = 1'b1;
      acc1 = -32'sd128;
      @(negedge clk);
      ls1 = 1'b0;
      acc1 = '0;
      cyc = 1;
      bad = 1'b0;
      while (!done1 && cyc < 100) begin
         if (!busy1) bad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk("n1_latency", cyc, LAT + 4);
      chk("n1_busy_at_done", busy1, 1'b1);
      chk("n1_busy_gap", bad, 1'b0);
      chk("n1_act_starts", n_starts1 - s0, 1);
      chk("n1_layer_out", out1, 8'hC0);
      @(negedge clk);
      chk("n1_busy_after", busy1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so a stuck design cannot hang the run
   initial begin : time_limit
      #200000;
      $display("FAIL time_limit: simulation still running at %0t", $time);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/act_sequencer.md
ACT_SEQUENCER -- requirements
Module: act_sequencer

Interface
REQ-001 Parameter NUM_NEURONS, default 10: accumulator lanes per layer, range 1..1024.
REQ-002 Parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-003 Parameter OUT_WIDTH, default 8: signed activation result width.
REQ-004 Parameter TIMEOUT_CYCLES, default 256: watchdog limit, used only under ACT_TIMEOUT_EN.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 layer_start  in  1  one-cycle pulse: capture acc_vec and begin the layer.
REQ-008 acc_vec  in  NUM_NEURONS*ACC_WIDTH  signed accumulators; lane i at bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-009 act_start  out  1  one-cycle request to the activation unit.
REQ-010 act_data  out  ACC_WIDTH  operand for the activation unit; stable from act_start until act_done.
REQ-011 act_done  in  1  one-cycle completion pulse from the activation unit.
REQ-012 act_result  in  OUT_WIDTH  activation result; valid in the act_done cycle.
REQ-013 layer_out  out  NUM_NEURONS*OUT_WIDTH  results, lane i at [i*OUT_WIDTH +: OUT_WIDTH].
REQ-014 layer_done  out  1  one-cycle pulse: all lanes written.
REQ-015 busy  out  1  high from layer_start acceptance until the layer_done cycle inclusive.
REQ-016 timeout_err  out  1  sticky watchdog flag (tied 0 without ACT_TIMEOUT_EN).

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT, STORE, FINISH.
REQ-018 IDLE: on layer_start, copy acc_vec into an internal buffer, clear lane index to 0, go to ISSUE.
REQ-019 ISSUE: drive act_data = buffer[index], pulse act_start for exactly one cycle, go to WAIT.
REQ-020 WAIT: on act_done, register act_result into layer_out lane index, go to STORE; act_done in any other state SHALL be ignored.
REQ-021 STORE: if index == NUM_NEURONS-1 go to FINISH, else increment index and go to ISSUE.
REQ-022 FINISH: pulse layer_done one cycle, return to IDLE; layer_out holds until the next layer's writes.
REQ-023 layer_start while busy SHALL be ignored; acc_vec changes after capture SHALL not affect results.
REQ-024 Overhead SHALL be 3 cycles per lane plus activation latency L; total layer latency = NUM_NEURONS*(L+3)+1 cycles from layer_start to layer_done.
REQ-025 act_done in the same cycle as act_start SHALL NOT be accepted (WAIT entered only the cycle after).
REQ-026 Lanes not yet written in the current layer SHALL keep their previous values.
REQ-027 Index counter SHALL be $clog2(NUM_NEURONS) bits min 1, never wrap past NUM_NEURONS-1.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, index 0, act_start 0, act_data 0, layer_out all 0, layer_done 0, busy 0, timeout_err 0.
REQ-029 Reset mid-layer SHALL abandon the layer with no layer_done; a late act_done after release SHALL be ignored.

Configuration
REQ-030 Macro ACT_TIMEOUT_EN defined: WAIT counts cycles; on reaching TIMEOUT_CYCLES without act_done, write lane value 0, set timeout_err, go to STORE; counter clears on entering WAIT.
REQ-031 Macro undefined: no counter, WAIT lasts indefinitely, timeout_err constant 0.
REQ-032 timeout_err SHALL clear only on reset.

Structure
REQ-033 Shared package act_pkg SHALL hold the state enum type act_seq_state_t and default width constants ACC_WIDTH_DEF=32, OUT_WIDTH_DEF=8.
REQ-034 One sub-module act_watchdog (counter, clear, expire flag) SHALL be instantiated only under ACT_TIMEOUT_EN.

Verification
REQ-035 NUM_NEURONS=4, acc_vec={40,-3,0,127}, model returns input/2 after L=5 -> layer_out={20,-1,0,63}, layer_done at cycle 33, four act_start pulses.
REQ-036 layer_start reissued during WAIT with different acc_vec -> ignored, results from first vector only.
REQ-037 rst_n deasserted low in WAIT of lane 2, act_done pulsed after release -> IDLE, layer_out all 0, no layer_done.
REQ-038 act_done asserted spuriously in IDLE and coincident with act_start -> no lane write, index unchanged.
REQ-039 ACT_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never answers lane 1 -> lane 1=0, timeout_err=1, remaining lanes complete normally.
REQ-040 NUM_NEURONS=1, acc_vec=-128 -> single act_start, layer_done after L+4 cycles, busy high throughout.
